// File: rtl/speech_cmd_decider_if.sv
// Classifier-to-decider frame handshake: one frame per cls_valid & cls_ready.
interface speech_cmd_decider_if #(
    parameter int CONF_W = 8
);
    logic              cls_valid;
    logic              cls_ready;
    logic [1:0]        cls_label;
    logic [CONF_W-1:0] cls_conf;

    modport master (output cls_valid, cls_label, cls_conf, input cls_ready);
    modport slave  (input cls_valid, cls_label, cls_conf, output cls_ready);
endinterface

// File: rtl/speech_cmd_decider.sv
// Confirms an on/off command after N_CONSEC consecutive confident matching frames, then cools down.
// Latency: speech_rec/cmd_strobe two cycles after acceptance of the confirming frame.
// Backpressure: cls_ready drops only for the single EMIT cycle; SPEECH_CMD_HOLD_EN makes speech_rec sticky.
module speech_cmd_decider #(
    parameter int CONF_W       = 8,
    parameter int CONF_THR     = 160,
    parameter int N_CONSEC     = 3,
    parameter int GAP_CYC      = 2000,
    parameter int COOLDOWN_CYC = 50000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    speech_cmd_decider_if.slave  cls,
    output logic [1:0]           speech_rec,
    output logic                 cmd_strobe,
    output logic                 busy
);
    localparam int TMR_MAX = (GAP_CYC > COOLDOWN_CYC) ? GAP_CYC : COOLDOWN_CYC;
    localparam int CNT_W   = $clog2(N_CONSEC + 1);
    localparam int TMR_W   = (TMR_MAX > 0) ? $clog2(TMR_MAX + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_CONSEC - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(GAP_CYC);
    localparam logic [TMR_W-1:0] CD_LD    = TMR_W'(COOLDOWN_CYC);

    typedef enum logic [1:0] {IDLE, COUNT, EMIT, COOLDOWN} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic [1:0]       cand, cand_nxt;
    logic [1:0]       rec_nxt;
    logic             strobe_nxt;
    logic             accept;
    logic             qual;

    assign accept = cls.cls_valid & cls.cls_ready;
    assign qual   = accept
                  & ((cls.cls_label == 2'd1) | (cls.cls_label == 2'd2))
                  & (cls.cls_conf >= CONF_W'(CONF_THR));

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        tmr_nxt    = tmr;
        cand_nxt   = cand;
        strobe_nxt = 1'b0;
`ifdef SPEECH_CMD_HOLD_EN
        rec_nxt    = speech_rec;
`else
        rec_nxt    = 2'd0;
`endif
        case (state)
            IDLE: begin
                if (qual) begin
                    cand_nxt  = cls.cls_label;
                    cnt_nxt   = CNT_ONE;
                    tmr_nxt   = GAP_LD;
                    state_nxt = (N_CONSEC == 1) ? EMIT : COUNT;
                end
            end
            COUNT: begin
                if (accept) begin
                    // An arriving frame takes precedence over a gap expiring in the same cycle.
                    tmr_nxt = GAP_LD;
                    if (!qual) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cls.cls_label == cand) begin
                        cnt_nxt = cnt + CNT_ONE;
                        if (cnt == CNT_LAST) begin
                            state_nxt = EMIT;
                        end
                    end else begin
                        cand_nxt = cls.cls_label;
                        cnt_nxt  = CNT_ONE;
                    end
                end else if (tmr <= TMR_ONE) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    tmr_nxt   = '0;
                end else begin
                    tmr_nxt = tmr - TMR_ONE;
                end
            end
            EMIT: begin
                strobe_nxt = 1'b1;
                rec_nxt    = cand;
                cnt_nxt    = '0;
                if (COOLDOWN_CYC == 0) begin
                    state_nxt = IDLE;
                    tmr_nxt   = '0;
                end else begin
                    state_nxt = COOLDOWN;
                    tmr_nxt   = CD_LD;
                end
            end
            COOLDOWN: begin
                // Frames are still accepted here so the classifier never stalls; they are discarded.
                if (tmr <= TMR_ONE) begin
                    state_nxt = IDLE;
                    tmr_nxt   = '0;
                end else begin
                    tmr_nxt = tmr - TMR_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                tmr_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            tmr           <= '0;
            cand          <= 2'd0;
            speech_rec    <= 2'd0;
            cmd_strobe    <= 1'b0;
            busy          <= 1'b0;
            cls.cls_ready <= 1'b1;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            tmr           <= tmr_nxt;
            cand          <= cand_nxt;
            speech_rec    <= rec_nxt;
            cmd_strobe    <= strobe_nxt;
            busy          <= (state_nxt != IDLE);
            cls.cls_ready <= (state_nxt != EMIT);
        end
    end
endmodule

// File: tb/tb_speech_cmd_decider.sv
// Directed scenarios plus random frames, checked every cycle against an event-level reference model.
module tb_speech_cmd_decider;
    localparam int THR = 160;
    localparam int N   = 3;
    localparam int GAP = 10;
    localparam int CD  = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] speech_rec;
    logic       cmd_strobe;
    logic       busy;

    speech_cmd_decider_if #(.CONF_W(8)) cls_if ();

    speech_cmd_decider #(
        .CONF_W(8), .CONF_THR(THR), .N_CONSEC(N), .GAP_CYC(GAP), .COOLDOWN_CYC(CD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cls(cls_if),
        .speech_rec(speech_rec), .cmd_strobe(cmd_strobe), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: frames are events at edge numbers; windows are plain arithmetic on them.
    int edge_n     = 0;
    int m_emit     = -100;
    int m_emit_lbl = 0;
    int m_cd_end   = -100;
    int m_last     = -100;
    int m_cand     = 0;
    int m_cnt      = 0;
    int m_hold     = 0;
    bit m_counting = 0;
    bit m_ready    = 1;
    bit m_strobe   = 0;
    bit m_busy     = 0;
    int m_rec      = 0;

    int dut_strobes  = 0;
    int dut_last_rec = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_emit = -100; m_cd_end = -100; m_last = -100;
        m_counting = 0; m_cnt = 0; m_hold = 0;
        m_ready = 1; m_strobe = 0; m_busy = 0; m_rec = 0;
    endtask

    task automatic model_edge(input logic v, input logic [1:0] lb, input logic [7:0] cf);
        bit acc, q;
        acc = v && m_ready;
        if (m_counting && (edge_n - m_last > GAP)) m_counting = 0;
        if (acc && edge_n > m_cd_end) begin
            q = (lb == 2'd1 || lb == 2'd2) && (int'(cf) >= THR);
            if (!q) m_counting = 0;
            else if (m_counting && int'(lb) == m_cand) m_cnt++;
            else begin
                m_counting = 1; m_cand = int'(lb); m_cnt = 1;
            end
            m_last = edge_n;
            if (m_counting && m_cnt == N) begin
                m_emit = edge_n; m_emit_lbl = m_cand;
                m_cd_end = edge_n + 1 + CD; m_counting = 0;
            end
        end
        m_ready  = (edge_n != m_emit);
        m_strobe = (edge_n == m_emit + 1);
        if (m_strobe) m_hold = m_emit_lbl;
`ifdef SPEECH_CMD_HOLD_EN
        m_rec = m_hold;
`else
        m_rec = m_strobe ? m_emit_lbl : 0;
`endif
        m_busy = (m_counting && (edge_n - m_last < GAP)) || (edge_n >= m_emit && edge_n < m_cd_end);
    endtask

    task automatic tick(input logic v, input logic [1:0] lb, input logic [7:0] cf);
        cls_if.cls_valid = v;
        cls_if.cls_label = lb;
        cls_if.cls_conf  = cf;
        @(posedge clk);
        edge_n++;
        model_edge(v, lb, cf);
        @(negedge clk);
        if (cmd_strobe === 1'b1) begin
            dut_strobes++;
            dut_last_rec = int'(speech_rec);
        end
        chk("cls_ready", 32'(cls_if.cls_ready), 32'(m_ready));
        chk("cmd_strobe", 32'(cmd_strobe), 32'(m_strobe));
        chk("speech_rec", 32'(speech_rec), 32'(m_rec));
        chk("busy", 32'(busy), 32'(m_busy));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 2'd0, 8'd0);
    endtask

    initial begin
        logic [1:0] lbl_seq [6];
        logic       v;
        logic [1:0] lb;
        logic [7:0] cf;

        cls_if.cls_valid = 1'b0;
        cls_if.cls_label = 2'd0;
        cls_if.cls_conf  = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_speech_rec", 32'(speech_rec), 32'd0);
        chk("rst_cmd_strobe", 32'(cmd_strobe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cls_ready", 32'(cls_if.cls_ready), 32'd1);
        rst_n = 1'b1;

        // Three confident "on" frames.
        dut_strobes = 0;
        repeat (3) tick(1'b1, 2'd1, 8'd200);
        chk("t1_busy_after_frames", 32'(busy), 32'd1);
        idle(2);
        chk("t1_busy_in_cooldown", 32'(busy), 32'd1);
        idle(CD + 3);
        chk("t1_strobes", 32'(dut_strobes), 32'd1);
        chk("t1_label", 32'(dut_last_rec), 32'd1);
        chk("t1_busy_after_cooldown", 32'(busy), 32'd0);

        // Interrupted run of "off": only the last three confirm.
        dut_strobes = 0;
        lbl_seq = '{2'd2, 2'd2, 2'd0, 2'd2, 2'd2, 2'd2};
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, lbl_seq[i], 8'd200);
            if (i == 4) chk("t2_no_early_emit", 32'(dut_strobes), 32'd0);
        end
        idle(CD + 4);
        chk("t2_strobes", 32'(dut_strobes), 32'd1);
        chk("t2_label", 32'(dut_last_rec), 32'd2);

        // Confidence just below threshold breaks the run; exactly at threshold qualifies.
        dut_strobes = 0;
        tick(1'b1, 2'd1, 8'd200);
        tick(1'b1, 2'd1, 8'd200);
        tick(1'b1, 2'd1, 8'd159);
        idle(2);
        chk("t3_no_emit", 32'(dut_strobes), 32'd0);
        chk("t3_idle", 32'(busy), 32'd0);
        repeat (3) tick(1'b1, 2'd1, 8'd160);
        idle(CD + 4);
        chk("t3_thr_emits", 32'(dut_strobes), 32'd1);

        // Gap expiry: the late frame starts a new run of one.
        dut_strobes = 0;
        repeat (2) tick(1'b1, 2'd2, 8'd220);
        idle(GAP + 1);
        tick(1'b1, 2'd2, 8'd220);
        idle(2);
        chk("t4_no_emit", 32'(dut_strobes), 32'd0);
        repeat (2) tick(1'b1, 2'd2, 8'd220);
        idle(2);
        chk("t4_cnt_restarted_at_one", 32'(dut_strobes), 32'd1);
        idle(CD + 2);
        // Frames just inside the gap window keep counting.
        dut_strobes = 0;
        tick(1'b1, 2'd1, 8'd200);
        idle(GAP - 2);
        tick(1'b1, 2'd1, 8'd200);
        idle(GAP - 2);
        tick(1'b1, 2'd1, 8'd200);
        idle(2);
        chk("t4_within_gap_emits", 32'(dut_strobes), 32'd1);
        idle(CD + 2);

        // Frames inside cooldown are dropped.
        dut_strobes = 0;
        repeat (3) tick(1'b1, 2'd1, 8'd200);
        idle(2);
        repeat (3) tick(1'b1, 2'd2, 8'd200);
        idle(CD);
        chk("t5_dropped", 32'(dut_strobes), 32'd1);
        repeat (3) tick(1'b1, 2'd2, 8'd200);
        idle(3);
        chk("t5_after_cooldown", 32'(dut_strobes), 32'd2);
        chk("t5_label", 32'(dut_last_rec), 32'd2);
        idle(CD + 2);

        // Reset asserted mid-count clears everything at once.
        repeat (2) tick(1'b1, 2'd1, 8'd200);
        cls_if.cls_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_speech_rec", 32'(speech_rec), 32'd0);
        chk("midrst_cmd_strobe", 32'(cmd_strobe), 32'd0);
        chk("midrst_cls_ready", 32'(cls_if.cls_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        dut_strobes = 0;
        tick(1'b1, 2'd1, 8'd200);
        idle(2);
        chk("midrst_candidate_aborted", 32'(dut_strobes), 32'd0);
        idle(GAP + 2);

        // Random frames biased toward runs and near-threshold confidence.
        for (int i = 0; i < 600; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            lb = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(1, 2));
            case ($urandom_range(0, 3))
                0:       cf = 8'd159;
                1:       cf = 8'd160;
                2:       cf = 8'd230;
                default: cf = 8'($urandom_range(0, 255));
            endcase
            if ($urandom_range(0, 29) == 0) idle($urandom_range(1, 14));
            tick(v, lb, cf);
        end
        idle(CD + 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
